dmem_bytelane: RTL and testbench
================================

Name: dmem_bytelane

Overview:
- Parametrised successor to the processor's word-only data memory.
- Takes byte addresses and supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Reads are registered and use a one-cycle req/rvalid handshake.
- Clears the whole array after reset with a sequential init state machine, instead of a partial asynchronous clear.
- Sits between the datapath LSU/control and the writeback mux.

Parameters:
- ADDR_W, 12, byte-address width; word depth = 2**(ADDR_W-2).
- INIT_VAL, 32'h0000_0000, value written to every word during the init sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  access request, sampled on rising clk edge.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  block accepts a request this cycle.
- rvalid  out  1  one-cycle pulse: rdata valid.
- rdata  out  32  extended load result.
- misalign  out  1  misaligned-access indication (see Optional Feature).

Behaviour:
- Reset values: ready=0, rvalid=0, rdata=0, misalign=0; state=INIT, init counter=0.
- State INIT:
  - Each cycle writes INIT_VAL to word[cnt], then cnt++.
  - After the write of word DEPTH-1, go to IDLE. INIT lasts exactly DEPTH cycles.
  - ready=0 throughout; req is ignored.
- State IDLE:
  - ready=1.
  - A request is accepted when req && ready. One access per cycle; back-to-back accepts are allowed.
- Word index = addr[ADDR_W-1:2]. Lane offset = addr[1:0].
- Store:
  - Byte enables: byte → 1 << addr[1:0]; half → 4'b0011 << addr[1:0] (offset 0 or 2); word → 4'b1111.
  - wdata is replicated across lanes: byte ×4, half ×2.
  - Write commits on the accepting edge. No rvalid is produced; rdata holds its previous value.
- Load:
  - The word is read on the accepting edge.
  - The selected lane is shifted down and extended (bit 7 or bit 15 when uns=0), then registered into rdata.
  - rvalid=1 in the following cycle only. Latency is 1 cycle.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- There is no address-0 special case. Address 0 is an ordinary location.
- Async reset mid-INIT or mid-access:
  - Immediately forces state=INIT, cnt=0, rvalid=0.
  - The in-flight load is dropped, and the init sweep restarts from word 0.
- Misalignment is half with addr[0]=1, or word with addr[1:0]≠0. Handling depends on the macro.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned store is suppressed (no byte enable asserted).
  - A misaligned load produces rdata=0 with rvalid=1.
  - misalign pulses high for one cycle, aligned with the cycle rvalid would occur, for both loads and stores.
- Undefined:
  - misalign is tied to 0.
  - Offending low address bits are forced to zero (half → addr[0]=0, word → addr[1:0]=0) and the access proceeds aligned.

Decomposition:
- Shared package dmem_pkg holds:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_RSVD};
  - enum state_e {ST_INIT, ST_IDLE};
  - function lane_extract(word, off, size, uns) returning the 32-bit extended value.
- One sub-module, dmem_lane_ram: a 4×8-bit byte-enabled synchronous array with a registered read, no reset on the storage.
- The top module holds the FSM, init counter, enable/replication logic, extension and the misalign path.

Test Plan:
- Init: release rst, hold req=1 → ready=0 for DEPTH (1024) cycles, then ready=1. A word load at 0x3FC returns 0 with rvalid one cycle after accept.
- Byte stores: SB 0xAA@0x10, 0xBB@0x11, 0xCC@0x12, 0xDD@0x13; LW 0x10 → 0xDDCCBBAA. LB 0x13 → 0xFFFFFFDD. LBU 0x13 → 0x000000DD.
- Half: SW 0x20 = 0x12348765. LH 0x20 → 0xFFFF8765. LHU 0x22 → 0x00001234. SH 0xBEEF@0x22 then LW 0x20 → 0xBEEF8765.
- Back-to-back: SW 0x30 = 0xCAFEF00D in cycle n, LW 0x30 in cycle n+1 → rvalid at n+2, rdata 0xCAFEF00D.
- Misaligned:
  - Setup: SW 0x40 = 0x11223344.
  - Defined: LW 0x41 → rdata 0, misalign pulse; SH@0x43 leaves 0x40 unchanged.
  - Undefined: LW 0x41 → 0x11223344, misalign=0.
- Reset mid-INIT (cycle 500) and mid-load: rvalid drops at once, and ready stays 0 for a further full 1024 cycles after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and load-lane extraction for the byte-lane data memory
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSVD} size_e;
    typedef enum logic {ST_INIT, ST_IDLE} state_e;

    // Shift the addressed lane down to bit 0 and extend it; word and reserved return the word as-is
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input size_e size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    lane_extract = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_H:    lane_extract = {{16{~uns & sh[15]}}, sh[15:0]};
            default: lane_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// rtl/dmem_lane_ram.sv - 4 x 8-bit byte-enabled synchronous word array with registered read
module dmem_lane_ram #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - byte-addressed data memory with init sweep; DMEM_MISALIGN_TRAP_EN selects trap vs. force-align
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              misalign
);

    localparam int IDX_W = ADDR_W - 2;

    state_e           state, state_nx;
    logic [IDX_W-1:0] cnt;
    size_e            sz;
    logic             accept, mis, drop;
    logic [1:0]       off;
    logic [3:0]       be_acc, ram_be;
    logic [31:0]      wrep, ram_wdata, ram_q, rdata_q;
    logic [IDX_W-1:0] ram_idx;
    logic [1:0]       off_q;
    size_e            size_q;
    logic             uns_q, drop_q;

    assign sz     = size_e'(size);
    assign ready  = (state == ST_IDLE);
    assign accept = req && ready;
    assign mis    = ((sz == SZ_H) && addr[0]) ||
                    ((sz == SZ_W || sz == SZ_RSVD) && (addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign drop = mis;
`else
    assign drop = 1'b0;
`endif

    // Offset with offending low bits cleared; irrelevant for trapped accesses since they are dropped
    always_comb begin
        off    = 2'b00;
        be_acc = 4'b1111;
        wrep   = wdata;
        case (sz)
            SZ_B: begin
                off    = addr[1:0];
                be_acc = 4'b0001 << off;
                wrep   = {4{wdata[7:0]}};
            end
            SZ_H: begin
                off    = {addr[1], 1'b0};
                be_acc = 4'b0011 << off;
                wrep   = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_be    = 4'b0000;
        ram_wdata = wrep;
        ram_idx   = addr[ADDR_W-1:2];
        if (state == ST_INIT) begin
            ram_be    = 4'b1111;
            ram_wdata = INIT_VAL;
            ram_idx   = cnt;
        end else if (accept && we && !drop) begin
            ram_be = be_acc;
        end
    end

    dmem_lane_ram #(.IDX_W(IDX_W)) u_ram (
        .clk   (clk),
        .idx   (ram_idx),
        .be    (ram_be),
        .wdata (ram_wdata),
        .re    (accept && !we),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INIT;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT: if (cnt == '1) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rvalid  <= 1'b0;
            rdata_q <= '0;
            off_q   <= 2'b00;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            cnt    <= (state == ST_INIT) ? cnt + 1'b1 : '0;
            rvalid <= accept && !we;
            if (accept && !we) begin
                off_q  <= off;
                size_q <= sz;
                uns_q  <= uns;
                drop_q <= drop;
            end
            if (rvalid) rdata_q <= rdata;
        end
    end

    // The RAM holds the raw word; extraction happens on its registered output and is held afterwards
    assign rdata = rvalid ? (drop_q ? 32'h0 : lane_extract(ram_q, off_q, size_q, uns_q)) : rdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= accept && mis;
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - randomized self-checking bench for dmem_bytelane against a word-array model
module tb_dmem_bytelane;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, we, uns;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata, rdata;
    logic        ready, rvalid, misalign;

    logic [31:0] model [1024];
    logic [31:0] last;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dmem_bytelane dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid),
        .rdata(rdata), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        last = 32'h0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        req = 1'b0;
        check(tag, n, 1024);
    endtask

    // One access accepted on the next edge; results checked one time unit after that edge
    task automatic acc(input bit w, input logic [1:0] sz, input bit u,
                       input logic [11:0] a, input logic [31:0] d);
        bit          m;
        int          idx, off;
        logic [31:0] v, exp;
        m   = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
        idx = int'(a[11:2]);
        off = int'(a[1:0]);
        if (!TRAP) begin
            if (sz == 2'd1) off = off & 2;
            else if (sz >= 2'd2) off = 0;
        end
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (w) begin
            if (!(TRAP && m)) begin
                case (sz)
                    2'd0:    model[idx][off*8 +: 8]  = d[7:0];
                    2'd1:    model[idx][off*8 +: 16] = d[15:0];
                    default: model[idx] = d;
                endcase
            end
            check("st_rvalid", rvalid, 0);
            check("st_rdata_hold", rdata, last);
        end else begin
            if (TRAP && m) exp = 32'h0;
            else begin
                v = model[idx] >> (off * 8);
                case (sz)
                    2'd0: begin
                        exp = v & 32'hFF;
                        if (!u && exp[7]) exp = exp | 32'hFFFF_FF00;
                    end
                    2'd1: begin
                        exp = v & 32'hFFFF;
                        if (!u && exp[15]) exp = exp | 32'hFFFF_0000;
                    end
                    default: exp = v;
                endcase
            end
            check("ld_rvalid", rvalid, 1);
            check("ld_rdata", rdata, exp);
            last = exp;
        end
        check("misalign", misalign, TRAP && m);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_misalign", misalign, 0);

        // Request held during the sweep must be ignored
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 12'h3FC; wdata = 32'hDEAD_BEEF;
        #2 rst = 1'b1;
        wait_init("init_len");
        acc(0, 2'd2, 0, 12'h3FC, 0);     check("init_lw_3fc", rdata, 32'h0);

        acc(1, 2'd0, 0, 12'h010, 32'hAA);
        acc(1, 2'd0, 0, 12'h011, 32'hBB);
        acc(1, 2'd0, 0, 12'h012, 32'hCC);
        acc(1, 2'd0, 0, 12'h013, 32'hDD);
        acc(0, 2'd2, 0, 12'h010, 0);     check("lw_10", rdata, 32'hDDCC_BBAA);
        acc(0, 2'd0, 0, 12'h013, 0);     check("lb_13", rdata, 32'hFFFF_FFDD);
        acc(0, 2'd0, 1, 12'h013, 0);     check("lbu_13", rdata, 32'h0000_00DD);

        acc(1, 2'd2, 0, 12'h020, 32'h1234_8765);
        acc(0, 2'd1, 0, 12'h020, 0);     check("lh_20", rdata, 32'hFFFF_8765);
        acc(0, 2'd1, 1, 12'h022, 0);     check("lhu_22", rdata, 32'h0000_1234);
        acc(1, 2'd1, 0, 12'h022, 32'hBEEF);
        acc(0, 2'd2, 0, 12'h020, 0);     check("sh_lw_20", rdata, 32'hBEEF_8765);

        acc(1, 2'd2, 0, 12'h030, 32'hCAFE_F00D);
        acc(0, 2'd2, 0, 12'h030, 0);     check("b2b_lw_30", rdata, 32'hCAFE_F00D);

        acc(1, 2'd2, 0, 12'h040, 32'h1122_3344);
        acc(0, 2'd2, 0, 12'h041, 0);
        check("mis_lw_41", rdata, TRAP ? 32'h0 : 32'h1122_3344);
        acc(1, 2'd1, 0, 12'h043, 32'hBEEF);
        acc(0, 2'd2, 0, 12'h040, 0);
        check("mis_sh_43", rdata, TRAP ? 32'h1122_3344 : 32'hBEEF_3344);

        for (int i = 0; i < 400; i++) begin
            acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                12'($urandom_range(0, 127)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                check("idle_rvalid", rvalid, 0);
            end
        end

        // Reset during a load's valid cycle
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 12'h010;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("preload_rvalid", rvalid, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_load_rvalid", rvalid, 0);
        check("rst_load_ready", ready, 0);
        check("rst_load_rdata", rdata, 0);
        #1 rst = 1'b1;

        // Reset again in the middle of the sweep
        repeat (500) @(posedge clk);
        #1;
        check("mid_init_ready", ready, 0);
        #1 rst = 1'b0;
        #1;
        check("mid_init_rvalid", rvalid, 0);
        rst = 1'b1;
        model_clear();
        wait_init("reinit_len");
        acc(0, 2'd2, 0, 12'h010, 0);     check("reinit_lw_10", rdata, 32'h0);
        acc(0, 2'd2, 0, 12'h030, 0);     check("reinit_lw_30", rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
